// File: rtl/adc_pkg.sv
// Shared types and defaults for the serial ADC capture front end.
package adc_pkg;

    localparam int SAMPLE_W         = 8;
    localparam int SUM_W            = 10;
    localparam int CNT_W            = 16;
    localparam int ADC_CLK_DIV      = 24;
    localparam int ADC_SETUP_CYCLES = 72;
    localparam int ADC_CONV_CYCLES  = 864;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        CONV  = 2'd3
    } adc_state_t;

endpackage

// File: rtl/adc_serial_capture_if.sv
// Pin-level bundle between the capture controller and the ADC / downstream display logic.
interface adc_serial_capture_if;
    import adc_pkg::*;

    logic                EN;
    logic                ADDAT;
    logic                ADCSN;
    logic                ADCLK;
    logic [SAMPLE_W-1:0] SAMPLE;
    logic                SAMPLE_VLD;
    logic                BUSY;

    modport master (
        input  EN, ADDAT,
        output ADCSN, ADCLK, SAMPLE, SAMPLE_VLD, BUSY
    );

    modport slave (
        output EN, ADDAT,
        input  ADCSN, ADCLK, SAMPLE, SAMPLE_VLD, BUSY
    );
endinterface

// File: rtl/adc_avg4.sv
// Sliding 4-frame mean of raw ADC samples; strobes only once the window has filled since reset.
module adc_avg4
    import adc_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_vld,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_vld
);
    logic [SAMPLE_W-1:0] r_win0, r_win1, r_win2, r_win3;
    logic [SUM_W-1:0]    r_sum;
    logic [2:0]          r_fill;
    logic [SUM_W-1:0]    w_sum_nxt;

    // Running sum drops the oldest entry; window starts zeroed so the early sums stay exact.
    assign w_sum_nxt = r_sum - {2'b00, r_win3} + {2'b00, i_sample};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_win0   <= {SAMPLE_W{1'b0}};
            r_win1   <= {SAMPLE_W{1'b0}};
            r_win2   <= {SAMPLE_W{1'b0}};
            r_win3   <= {SAMPLE_W{1'b0}};
            r_sum    <= {SUM_W{1'b0}};
            r_fill   <= 3'd0;
            o_sample <= {SAMPLE_W{1'b0}};
            o_vld    <= 1'b0;
        end else if (i_vld) begin
            r_win0 <= i_sample;
            r_win1 <= r_win0;
            r_win2 <= r_win1;
            r_win3 <= r_win2;
            r_sum  <= w_sum_nxt;
            if (r_fill != 3'd4) begin
                r_fill <= r_fill + 3'd1;
            end
            if (r_fill >= 3'd3) begin
                o_sample <= w_sum_nxt[SUM_W-1:2];
                o_vld    <= 1'b1;
            end else begin
                o_vld    <= 1'b0;
            end
        end else begin
            o_vld <= 1'b0;
        end
    end
endmodule

// File: rtl/adc_serial_capture.sv
// TLC549-class serial ADC capture: drives ADCSN/ADCLK, shifts in 8 bits MSB-first per frame.
// Define ADC_AVG_EN to report the 4-frame sliding mean (adc_avg4) instead of the raw frame.
module adc_serial_capture
    import adc_pkg::*;
#(
    parameter int CLK_DIV      = ADC_CLK_DIV,
    parameter int SETUP_CYCLES = ADC_SETUP_CYCLES,
    parameter int CONV_CYCLES  = ADC_CONV_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RST,
    adc_serial_capture_if.master bus
);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);

    adc_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [3:0]          r_half, w_half_nxt;
    logic [1:0]          r_sync;
    logic [SAMPLE_W-1:0] r_shift;
    logic                r_adcsn, r_adclk, r_busy;
    logic                w_load, w_adclk_nxt, w_rise;

    // Next-state: r_cnt times each state; in SHIFT it times one ADCLK half period, r_half counts halves.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_half_nxt  = r_half;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt  = {CNT_W{1'b0}};
                w_half_nxt = 4'd0;
                if (bus.EN) begin
                    w_state_nxt = SETUP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            SHIFT: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                    if (r_half == 4'd15) begin
                        w_state_nxt = CONV;
                        w_half_nxt  = 4'd0;
                        w_load      = 1'b1;
                    end else begin
                        w_half_nxt  = r_half + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            CONV: begin
                if (r_cnt == CONV_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_half_nxt  = 4'd0;
            end
        endcase
    end

    // Odd half periods are the high phase; the capture edge is where the register goes 0->1.
    assign w_adclk_nxt = (w_state_nxt == SHIFT) && w_half_nxt[0];
    assign w_rise      = w_adclk_nxt && !r_adclk;

    // State, counters, synchronizer, shift register and pin registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_half  <= 4'd0;
            r_sync  <= 2'b00;
            r_shift <= {SAMPLE_W{1'b0}};
            r_adcsn <= 1'b1;
            r_adclk <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_half  <= w_half_nxt;
            r_sync  <= {r_sync[0], bus.ADDAT};
            r_adcsn <= (w_state_nxt == IDLE) || (w_state_nxt == CONV);
            r_adclk <= w_adclk_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_rise) begin
                r_shift <= {r_shift[SAMPLE_W-2:0], r_sync[1]};
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    assign bus.ADCSN = r_adcsn;
    assign bus.ADCLK = r_adclk;
    assign bus.BUSY  = r_busy;

`ifdef ADC_AVG_EN
    logic [SAMPLE_W-1:0] w_avg_sample;
    logic                w_avg_vld;

    adc_avg4 u_avg4 (
        .CLK      (CLK),
        .RST      (RST),
        .i_sample (r_shift),
        .i_vld    (w_load),
        .o_sample (w_avg_sample),
        .o_vld    (w_avg_vld)
    );

    assign bus.SAMPLE     = w_avg_sample;
    assign bus.SAMPLE_VLD = w_avg_vld;
`else
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_sample_vld;

    // Raw sample register loads on the edge that enters CONV.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sample     <= {SAMPLE_W{1'b0}};
            r_sample_vld <= 1'b0;
        end else if (w_load) begin
            r_sample     <= r_shift;
            r_sample_vld <= 1'b1;
        end else begin
            r_sample_vld <= 1'b0;
        end
    end

    assign bus.SAMPLE     = r_sample;
    assign bus.SAMPLE_VLD = r_sample_vld;
`endif
endmodule

// File: tb/tb_adc_serial_capture.sv
// Self-checking bench for adc_serial_capture with a serial ADC model and an expected-sample queue.
module tb_adc_serial_capture;
    localparam int FRAME = 1 + 72 + 16 * 24 + 864;   // 1321
    localparam int LAT   = 1 + 72 + 16 * 24;         // 457, from the IDLE cycle that sees EN
    localparam int CSN_LOW = 72 + 16 * 24;           // 456

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic en  = 1'b0;
    logic adc_dat = 1'b0;

    adc_serial_capture_if bus ();
    assign bus.EN    = en;
    assign bus.ADDAT = adc_dat;

    adc_serial_capture dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];

    int cyc = 0, rise_cnt = 0, csn_low_cnt = 0, vld_cnt = 0, viol_cnt = 0;
    logic prev_adclk = 1'b0;
    logic p_csn = 1'b1, p_clk = 1'b0;
    logic [7:0] m_sh = 8'h00;

    // Monitor: event counters updated just after each active edge.
    always @(posedge CLK) begin
        #1;
        cyc        <= cyc + 1;
        prev_adclk <= bus.ADCLK;
        if (bus.ADCLK === 1'b1 && prev_adclk === 1'b0) rise_cnt <= rise_cnt + 1;
        if (bus.ADCSN === 1'b0) csn_low_cnt <= csn_low_cnt + 1;
        if (bus.ADCLK === 1'b1 && bus.ADCSN === 1'b1) viol_cnt <= viol_cnt + 1;
        if (bus.SAMPLE_VLD === 1'b1) vld_cnt <= vld_cnt + 1;
    end

    // ADC model: presents MSB on ADCSN fall, next bit on every ADCLK fall.
    always @(posedge CLK) begin
        #1;
        p_csn <= bus.ADCSN;
        p_clk <= bus.ADCLK;
        if (p_csn === 1'b1 && bus.ADCSN === 1'b0) begin
            if (stim_q.size() != 0) begin
                m_sh    <= stim_q[0];
                adc_dat <= stim_q[0][7];
                void'(stim_q.pop_front());
            end else begin
                m_sh    <= 8'h00;
                adc_dat <= 1'b0;
            end
        end else if (p_clk === 1'b1 && bus.ADCLK === 1'b0) begin
            m_sh    <= {m_sh[6:0], 1'b0};
            adc_dat <= m_sh[6];
        end
    end

    task automatic wait_vld(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.SAMPLE_VLD === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.BUSY === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rises(input int n, input int budget, output bit ok);
        int r0;
        r0 = rise_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (rise_cnt - r0 >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({bus.ADCSN, bus.ADCLK, bus.SAMPLE, bus.SAMPLE_VLD, bus.BUSY} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_state: got csn=%b clk=%b sample=%h vld=%b busy=%b, expected 1 0 00 0 0",
                         bus.ADCSN, bus.ADCLK, bus.SAMPLE, bus.SAMPLE_VLD, bus.BUSY);
            end
        end
        RST = 1'b0;
        en  = 1'b0;
    endtask

    task automatic test_single();
        int idle_edge, tv, r0, l0, v0;
        bit ok;
        logic [7:0] e;
        stim_q.push_back(8'hF5);
        exp_q.push_back(8'hF5);
        @(negedge CLK);
        r0 = rise_cnt; l0 = csn_low_cnt; v0 = vld_cnt;
        en = 1'b1;
        idle_edge = cyc;
        @(negedge CLK);
        en = 1'b0;
        wait_vld(LAT + 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout: no SAMPLE_VLD within %0d cycles", LAT + 50);
        end else begin
            tv = cyc;
            checks++;
            if (tv - idle_edge != LAT) begin
                errors++;
                $display("FAIL single_latency: got %0d expected %0d", tv - idle_edge, LAT);
            end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (bus.SAMPLE !== e) begin
                errors++;
                $display("FAIL single_sample: got %h expected %h", bus.SAMPLE, e);
            end
            @(negedge CLK);
            checks++;
            if (bus.SAMPLE_VLD !== 1'b0) begin
                errors++;
                $display("FAIL single_strobe_width: got vld=%b expected 0", bus.SAMPLE_VLD);
            end
            checks++;
            if (rise_cnt - r0 != 8) begin
                errors++;
                $display("FAIL single_rises: got %0d expected 8", rise_cnt - r0);
            end
            checks++;
            if (csn_low_cnt - l0 != CSN_LOW) begin
                errors++;
                $display("FAIL single_csn_low: got %0d expected %0d", csn_low_cnt - l0, CSN_LOW);
            end
            wait_idle(1000, ok);
            checks++;
            if (!ok || cyc - tv != 864 || bus.ADCSN !== 1'b1) begin
                errors++;
                $display("FAIL single_conv: got ok=%0d conv=%0d csn=%b expected 1 864 1", ok, cyc - tv, bus.ADCSN);
            end
            checks++;
            if (vld_cnt - v0 != 1 || viol_cnt != 0) begin
                errors++;
                $display("FAIL single_counts: got strobes=%0d violations=%0d expected 1 0", vld_cnt - v0, viol_cnt);
            end
        end
    endtask

    task automatic test_continuous();
        int t1, v0;
        bit ok;
        logic [7:0] e;
        stim_q.push_back(8'h00); exp_q.push_back(8'h00);
        stim_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        @(negedge CLK);
        v0 = vld_cnt;
        en = 1'b1;
        t1 = 0;
        for (int f = 0; f < 2; f++) begin
            wait_vld(FRAME + 50, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cont_timeout: frame %0d no strobe", f);
            end else begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (bus.SAMPLE !== e) begin
                    errors++;
                    $display("FAIL cont_sample: frame %0d got %h expected %h", f, bus.SAMPLE, e);
                end
                if (f == 1) begin
                    checks++;
                    if (cyc - t1 != FRAME) begin
                        errors++;
                        $display("FAIL cont_period: got %0d expected %0d", cyc - t1, FRAME);
                    end
                end
                t1 = cyc;
            end
        end
        en = 1'b0;
        wait_idle(1000, ok);
        repeat (1500) @(negedge CLK);
        checks++;
        if (vld_cnt - v0 != 2 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: got strobes=%0d busy=%b expected 2 0", vld_cnt - v0, bus.BUSY);
        end
    endtask

    task automatic test_en_drop();
        int v0, l0;
        bit ok;
        logic [7:0] e;
        stim_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        @(negedge CLK);
        v0 = vld_cnt; l0 = csn_low_cnt;
        en = 1'b1;
        wait_rises(3, 600, ok);
        en = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL endrop_rises: third ADCLK rise not seen");
        end
        wait_vld(600, ok);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (!ok || bus.SAMPLE !== e) begin
            errors++;
            $display("FAIL endrop_sample: got ok=%0d sample=%h expected 1 %h", ok, bus.SAMPLE, e);
        end
        wait_idle(1000, ok);
        repeat (1500) @(negedge CLK);
        checks++;
        if (vld_cnt - v0 != 1 || csn_low_cnt - l0 != CSN_LOW || bus.ADCSN !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL endrop_stop: got strobes=%0d csn_low=%0d csn=%b busy=%b expected 1 %0d 1 0",
                     vld_cnt - v0, csn_low_cnt - l0, bus.ADCSN, bus.BUSY, CSN_LOW);
        end
    endtask

    task automatic test_rst_abort();
        int v0, nf;
        bit ok;
        logic [7:0] e;
        pulse_reset();
        stim_q.push_back(8'hA5);
        @(negedge CLK);
        en = 1'b1;
        @(negedge CLK);
        en = 1'b0;
        wait_rises(4, 600, ok);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (!ok || {bus.ADCSN, bus.ADCLK, bus.SAMPLE_VLD, bus.BUSY, bus.SAMPLE} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL abort_state: got ok=%0d csn=%b clk=%b vld=%b busy=%b sample=%h expected 1 1 0 0 0 00",
                     ok, bus.ADCSN, bus.ADCLK, bus.SAMPLE_VLD, bus.BUSY, bus.SAMPLE);
        end
        RST = 1'b0;
        v0 = vld_cnt;
        repeat (600) @(negedge CLK);
        checks++;
        if (vld_cnt != v0 || bus.BUSY !== 1'b0 || bus.SAMPLE !== 8'h00) begin
            errors++;
            $display("FAIL abort_quiet: got strobes=%0d busy=%b sample=%h expected 0 0 00", vld_cnt - v0, bus.BUSY, bus.SAMPLE);
        end
`ifdef ADC_AVG_EN
        nf = 4;
`else
        nf = 1;
`endif
        for (int i = 0; i < nf; i++) stim_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        en = 1'b1;
        wait_vld(nf * FRAME + 50, ok);
        en = 1'b0;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (!ok || bus.SAMPLE !== e) begin
            errors++;
            $display("FAIL abort_recapture: got ok=%0d sample=%h expected 1 %h", ok, bus.SAMPLE, e);
        end
        wait_idle(1000, ok);
    endtask

    // Five back-to-back frames; expected values come from a bench-side 4-entry window when averaging.
    task automatic test_back_to_back();
        logic [7:0] vals[5];
        int win[4];
        int sum, idle_edge, t1, first, v0;
        bit ok;
        logic [7:0] e;
        vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h40; vals[4] = 8'h50;
        for (int k = 0; k < 4; k++) win[k] = 0;
        first = 0;
        for (int i = 0; i < 5; i++) begin
            stim_q.push_back(vals[i]);
            win[3] = win[2]; win[2] = win[1]; win[1] = win[0]; win[0] = int'(vals[i]);
            sum = win[0] + win[1] + win[2] + win[3];
`ifdef ADC_AVG_EN
            if (i >= 3) exp_q.push_back(8'(sum >> 2));
            first = 3;
`else
            exp_q.push_back(vals[i]);
`endif
        end
        pulse_reset();
        @(negedge CLK);
        v0 = vld_cnt;
        en = 1'b1;
        idle_edge = cyc;
        t1 = 0;
        for (int f = first; f < 5; f++) begin
            wait_vld((f == first) ? (first + 1) * FRAME + 50 : FRAME + 50, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_timeout: frame %0d no strobe", f);
            end else begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (bus.SAMPLE !== e) begin
                    errors++;
                    $display("FAIL b2b_sample: frame %0d got %h expected %h", f, bus.SAMPLE, e);
                end
                checks++;
                if (f == first && (cyc - idle_edge != first * FRAME + LAT || vld_cnt - v0 != 1)) begin
                    errors++;
                    $display("FAIL b2b_first: got time=%0d strobes=%0d expected %0d 1", cyc - idle_edge, vld_cnt - v0, first * FRAME + LAT);
                end else if (f != first && cyc - t1 != FRAME) begin
                    errors++;
                    $display("FAIL b2b_period: got %0d expected %0d", cyc - t1, FRAME);
                end
                t1 = cyc;
            end
        end
        en = 1'b0;
        wait_idle(1000, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got idle=%0d pending=%0d expected 1 0", ok, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
`ifndef ADC_AVG_EN
        test_single();
        test_continuous();
        test_en_drop();
`endif
        test_back_to_back();
        test_rst_abort();
        checks++;
        if (viol_cnt != 0) begin
            errors++;
            $display("FAIL adclk_while_csn_high: got %0d expected 0", viol_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
